// File: rtl/image_pipe_arb_pkg.sv
// Shared types, default sizes and the round-robin search used by the image pipe arbiter.
// Latency: n/a (types and a pure combinational function).
// Backpressure: n/a.
package image_pipe_arb_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_e;

  localparam int unsigned NREQ_DEF = 4;
  localparam int unsigned DW_DEF   = 32;
  localparam int unsigned NREQ_MAX = 8;

  // Returns {found, index}: the first requester with req set, scanning
  // (last+1) mod n, (last+2) mod n, ... so the previous owner is checked last.
  function automatic logic [3:0] rr_next(input logic [NREQ_MAX-1:0] req,
                                         input logic [2:0]          last,
                                         input int unsigned         n);
    logic [3:0]  res;
    int unsigned idx;
    res = '0;
    for (int unsigned k = 1; k <= NREQ_MAX; k++) begin
      if (k <= n && !res[3]) begin
        idx = (32'(last) + k) % n;
        if (req[3'(idx)]) res = {1'b1, 3'(idx)};
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/image_pipe_rr_picker.sv
// Combinational round-robin pick: one-hot winner and its index from a request vector.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the caller decides when the pick is taken.
// Ports: req_i request vector, last_i previous owner index,
//        gnt_o one-hot winner (zero when no request), idx_o winner index, vld_o any winner.
module image_pipe_rr_picker
  import image_pipe_arb_pkg::*;
#(
  parameter int unsigned NREQ = NREQ_DEF,
  parameter int unsigned IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IW-1:0]   last_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IW-1:0]   idx_o,
  output logic            vld_o
);

  logic [NREQ_MAX-1:0] req_pad;
  logic [3:0]          res;

  always_comb begin
    req_pad             = '0;
    req_pad[NREQ-1:0]   = req_i;
    res                 = rr_next(req_pad, 3'(last_i), NREQ);
    vld_o               = res[3];
    idx_o               = IW'(res[2:0]);
    for (int unsigned i = 0; i < NREQ; i++) begin
      gnt_o[i] = res[3] && (res[2:0] == 3'(i));
    end
  end

endmodule

// File: rtl/image_pipe_arbiter.sv
// Frame-granular round-robin arbiter merging NREQ requester streams into one image pipe.
// Latency: one IDLE cycle to grant; data/valid/end then pass to the pipe combinationally.
// Backpressure: owner sees pipe_busy_in directly; every non-owner (and all in IDLE) sees busy=1.
// Ports: clk, rst (async, active-high); req_data_in/req_valid_in/req_end_in/req_busy_out per
//        requester; pipe_data_out/pipe_valid_out/pipe_end_out/pipe_busy_in to the pipe;
//        grant_out one-hot owner. Build macro IMAGE_PIPE_ARB_STATS_EN adds frame_cnt_out
//        (16-bit completed-frame counter per requester, slice i = bits [i*16 +: 16]).
module image_pipe_arbiter
  import image_pipe_arb_pkg::*;
#(
  parameter int unsigned NREQ = NREQ_DEF,
  parameter int unsigned DW   = DW_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ*DW-1:0] req_data_in,
  input  logic [NREQ-1:0]   req_valid_in,
  input  logic [NREQ-1:0]   req_end_in,
  output logic [NREQ-1:0]   req_busy_out,
  output logic [DW-1:0]     pipe_data_out,
  output logic              pipe_valid_out,
  output logic              pipe_end_out,
  input  logic              pipe_busy_in,
  output logic [NREQ-1:0]   grant_out
`ifdef IMAGE_PIPE_ARB_STATS_EN
  ,output logic [NREQ*16-1:0] frame_cnt_out
`endif
);

  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  arb_state_e      state_q, state_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [IW-1:0]   owner_q, owner_d;
  logic [IW-1:0]   last_q,  last_d;

  logic [NREQ-1:0] pick_gnt;
  logic [IW-1:0]   pick_idx;
  logic            pick_vld;
  logic            owner_end_xfer;

  image_pipe_rr_picker #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_picker (
    .req_i  (req_valid_in),
    .last_i (last_q),
    .gnt_o  (pick_gnt),
    .idx_o  (pick_idx),
    .vld_o  (pick_vld)
  );

  // grant_q is zero outside GRANT, so masking with it covers the IDLE case too.
  assign owner_end_xfer = |(grant_q & req_valid_in & req_end_in) & ~pipe_busy_in;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    owner_d = owner_q;
    last_d  = last_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_vld) begin
          state_d = ST_GRANT;
          grant_d = pick_gnt;
          owner_d = pick_idx;
        end
      end
      ST_GRANT: begin
        // Ownership only ends on the owner's end word actually transferring.
        if (owner_end_xfer) begin
          state_d = ST_IDLE;
          grant_d = '0;
          last_d  = owner_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      owner_q <= '0;
      last_q  <= IW'(NREQ - 1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      owner_q <= owner_d;
      last_q  <= last_d;
    end
  end

  // Zero-latency mux from the owner; all-zero when no grant is held.
  always_comb begin
    pipe_data_out  = '0;
    pipe_valid_out = 1'b0;
    pipe_end_out   = 1'b0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (grant_q[i]) begin
        pipe_data_out  = req_data_in[i*DW +: DW];
        pipe_valid_out = req_valid_in[i];
        pipe_end_out   = req_end_in[i];
      end
    end
  end

  assign req_busy_out = ~grant_q | {NREQ{pipe_busy_in}};
  assign grant_out    = grant_q;

`ifdef IMAGE_PIPE_ARB_STATS_EN
  logic [NREQ*16-1:0] frame_cnt_q, frame_cnt_d;

  always_comb begin
    frame_cnt_d = frame_cnt_q;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (grant_q[i] && req_valid_in[i] && req_end_in[i] && !pipe_busy_in) begin
        frame_cnt_d[i*16 +: 16] = frame_cnt_q[i*16 +: 16] + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) frame_cnt_q <= '0;
    else     frame_cnt_q <= frame_cnt_d;
  end

  assign frame_cnt_out = frame_cnt_q;
`endif

endmodule

// File: doc/image_pipe_arbiter.md
IMAGE_PIPE_ARBITER -- requirements
Module: image_pipe_arbiter

Interface
REQ-001 Parameter NREQ, default 4: number of upstream requester streams, range 2..8.
REQ-002 Parameter DW, default 32: stream data width, all requesters and the pipe.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst  input  1  reset; asynchronous assert, active-high.
REQ-005 req_data_in  input  NREQ*DW  requester data, slice i = bits [i*DW +: DW].
REQ-006 req_valid_in  input  NREQ  requester word valid.
REQ-007 req_end_in  input  NREQ  last word of the requester's frame, qualified by valid.
REQ-008 req_busy_out  output  NREQ  per-requester stall; 1 = word not accepted this cycle.
REQ-009 pipe_data_out  output  DW  data to image pipe input (is_data_in).
REQ-010 pipe_valid_out  output  1  word valid to pipe (is_valid_in).
REQ-011 pipe_end_out  output  1  frame end to pipe (is_end_in).
REQ-012 pipe_busy_in  input  1  pipe stall (is_busy_out).
REQ-013 grant_out  output  NREQ  one-hot current owner, all-zero when idle.

Function
REQ-014 Transfer: a word moves when its valid=1 and its busy=0 at posedge clk; the arbiter does not drop or duplicate words.
REQ-015 FSM states IDLE, GRANT; reset enters IDLE.
REQ-016 IDLE: if any req_valid_in=1, pick the winner round-robin starting at (last_owner+1) mod NREQ, set grant_out to the winner's one-hot and go to GRANT the next cycle; else stay.
REQ-017 GRANT: pipe_data_out/valid/end = granted requester's signals (combinational mux, zero latency); req_busy_out[owner] = pipe_busy_in; all non-owners see busy=1.
REQ-018 GRANT -> IDLE on the cycle the owner's word with end=1 transfers; last_owner <= owner.
REQ-019 Arbitration is frame-granular: ownership never changes mid-frame, regardless of other requests.
REQ-020 IDLE: pipe_valid_out=0, pipe_end_out=0, req_busy_out all 1.
REQ-021 Frame-to-frame overhead is exactly one IDLE cycle; back-to-back frames from one sole requester are accepted with one bubble.
REQ-022 Owner valid low in GRANT: pipe_valid_out=0, ownership held (no timeout).
REQ-023 Single-word frame (valid=1, end=1 first word) is legal and returns to IDLE after its transfer.
REQ-024 pipe_data_out is don't-care when pipe_valid_out=0; driven 0 in IDLE.

Reset
REQ-025 While rst=1: state=IDLE, grant_out=0, last_owner=NREQ-1 (so requester 0 wins first), pipe_valid_out=0, pipe_end_out=0, pipe_data_out=0, req_busy_out all 1.
REQ-026 Reset mid-frame abandons the frame; no recovery of partial frame, first post-reset grant follows REQ-025.

Configuration
REQ-027 Macro IMAGE_PIPE_ARB_STATS_EN: when defined, adds output frame_cnt_out [NREQ*16], per-requester 16-bit count of completed frames (incremented on end-word transfer, wraps 0xFFFF->0, reset 0); when undefined, the port and counters do not exist.

Structure
REQ-028 Package image_pipe_arb_pkg holds the FSM state enum, default NREQ/DW constants and the round-robin next-winner function.
REQ-029 One sub-module, image_pipe_rr_picker: combinational round-robin one-hot pick from request vector and last_owner.

Verification
REQ-030 Single requester 0 sends 4-word frame, pipe_busy_in=0 -> grant_out=0001 one cycle after valid, 4 words on pipe in order, pipe_end_out on word 4, then IDLE.
REQ-031 Requesters 0..3 all valid continuously, 2-word frames -> grant order 0,1,2,3,0 with one IDLE cycle between frames.
REQ-032 Requester 2 mid-frame, requester 1 asserts valid -> req_busy_out[1]=1 until requester 2's end word transfers; requester 1 granted next.
REQ-033 pipe_busy_in=1 for 3 cycles mid-frame -> req_busy_out[owner]=1 for those cycles, data held, no word lost or duplicated.
REQ-034 rst pulse during word 2 of a frame -> outputs at REQ-025 values immediately; next request from requester 3 alone gets grant 1000.
REQ-035 With IMAGE_PIPE_ARB_STATS_EN, 65537 single-word frames from requester 0 -> frame_cnt_out[15:0]=1.
